// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target (slave) endpoint.
// Optional glitch filter: define I2C_SLAVE_GLITCH_FILTER_EN.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX_DATA,
        ST_RX_ACK,
        ST_TX_DATA,
        ST_TX_ACK
    } slaveState_t;

    localparam logic I2C_WRITE  = 1'b0;
    localparam logic I2C_READ   = 1'b1;

    // SDA levels of the acknowledge bit
    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;

    localparam int   I2C_ADDR_W = 7;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with START/STOP and SCL edge detection.
// I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample agreement filter per line.
module i2c_bus_sync (
    input  logic clkIn,
    input  logic rstIn,
    input  logic sclIn,
    input  logic sdaIn,
    output logic sdaLvl,
    output logic sclRise,
    output logic sclFall,
    output logic start,
    output logic stop
);

    logic [1:0] sclSync;
    logic [1:0] sdaSync;
    logic       sclLvl;
    logic       sclPrev;
    logic       sdaPrev;

    // Idle bus is high, so reset the whole chain to 1 to avoid false edges
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            sclSync <= 2'b11;
            sdaSync <= 2'b11;
        end else begin
            sclSync <= {sclSync[0], sclIn};
            sdaSync <= {sdaSync[0], sdaIn};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] sclHist;
    logic [1:0] sdaHist;
    logic       sclHeld;
    logic       sdaHeld;

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            sclHist <= 2'b11;
            sdaHist <= 2'b11;
            sclHeld <= 1'b1;
            sdaHeld <= 1'b1;
        end else begin
            sclHist <= {sclHist[0], sclSync[1]};
            sdaHist <= {sdaHist[0], sdaSync[1]};
            sclHeld <= sclLvl;
            sdaHeld <= sdaLvl;
        end
    end

    // Follow the line only once the current and two prior samples agree
    assign sclLvl = (sclHist == {2{sclSync[1]}}) ? sclSync[1] : sclHeld;
    assign sdaLvl = (sdaHist == {2{sdaSync[1]}}) ? sdaSync[1] : sdaHeld;
`else
    assign sclLvl = sclSync[1];
    assign sdaLvl = sdaSync[1];
`endif

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            sclPrev <= 1'b1;
            sdaPrev <= 1'b1;
        end else begin
            sclPrev <= sclLvl;
            sdaPrev <= sdaLvl;
        end
    end

    assign sclRise = sclLvl & ~sclPrev;
    assign sclFall = ~sclLvl & sclPrev;
    assign start   = sclLvl & sclPrev & sdaPrev & ~sdaLvl;
    assign stop    = sclLvl & sclPrev & ~sdaPrev & sdaLvl;

endmodule

// File: rtl/i2c_slave.sv
// I2C target endpoint: address match, write-FIFO push, FWFT read-FIFO pop.
// Optional glitch filter in i2c_bus_sync: I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  sclIn,
    inout  wire                   sdaBi,
    input  logic [DATA_WIDTH-1:0] rdDataIn,
    input  logic                  wrFifoFullIn,
    output logic [DATA_WIDTH-1:0] wrDataOut,
    output logic                  wrFifoEnOut,
    output logic                  rdFifoEnOut,
    output logic                  busyOut
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH);

    slaveState_t           state, stateNxt;
    logic [3:0]            bitCnt, bitNxt;
    logic [DATA_WIDTH-1:0] shiftReg, shiftNxt;
    logic [DATA_WIDTH-1:0] wrData, wrDataNxt;
    logic                  rwBit, rwNxt;
    logic                  sdaOut, sdaNxt;
    logic                  busy, busyNxt;
    logic                  wrEn, wrEnNxt;
    logic                  rdEn, rdEnNxt;

    logic sdaLvl, sclRise, sclFall, start, stop;

    i2c_bus_sync uSync (
        .clkIn   (clkIn),
        .rstIn   (rstIn),
        .sclIn   (sclIn),
        .sdaIn   (sdaBi),
        .sdaLvl  (sdaLvl),
        .sclRise (sclRise),
        .sclFall (sclFall),
        .start   (start),
        .stop    (stop)
    );

    // sdaOut is the wanted line level; a 1 is realised as release
    assign sdaBi       = (sdaOut || rstIn) ? 1'bz : 1'b0;
    assign wrDataOut   = wrData;
    assign wrFifoEnOut = wrEn;
    assign rdFifoEnOut = rdEn;
    assign busyOut     = busy;

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state    <= ST_IDLE;
            bitCnt   <= '0;
            shiftReg <= '0;
            wrData   <= '0;
            rwBit    <= I2C_WRITE;
            sdaOut   <= 1'b1;
            busy     <= 1'b0;
            wrEn     <= 1'b0;
            rdEn     <= 1'b0;
        end else begin
            state    <= stateNxt;
            bitCnt   <= bitNxt;
            shiftReg <= shiftNxt;
            wrData   <= wrDataNxt;
            rwBit    <= rwNxt;
            sdaOut   <= sdaNxt;
            busy     <= busyNxt;
            wrEn     <= wrEnNxt;
            rdEn     <= rdEnNxt;
        end
    end

    always_comb begin
        stateNxt  = state;
        bitNxt    = bitCnt;
        shiftNxt  = shiftReg;
        wrDataNxt = wrData;
        rwNxt     = rwBit;
        sdaNxt    = sdaOut;
        busyNxt   = busy;
        wrEnNxt   = 1'b0;
        rdEnNxt   = 1'b0;
        if (stop) begin
            stateNxt = ST_IDLE;
            sdaNxt   = 1'b1;
            busyNxt  = 1'b0;
        end else if (start) begin
            stateNxt = ST_ADDR;
            bitNxt   = '0;
            sdaNxt   = 1'b1;
            busyNxt  = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: sdaNxt = 1'b1;
                ST_ADDR: begin
                    if (sclRise) begin
                        shiftNxt = {shiftReg[DATA_WIDTH-2:0], sdaLvl};
                        bitNxt   = bitCnt + 4'd1;
                    end else if (sclFall && bitCnt == LAST_BIT) begin
                        if (shiftReg[DATA_WIDTH-1 -: I2C_ADDR_W] == SLAVE_ADDR) begin
                            stateNxt = ST_ADDR_ACK;
                            rwNxt    = shiftReg[0];
                            sdaNxt   = I2C_ACK;
                            busyNxt  = 1'b1;
                        end else begin
                            stateNxt = ST_IDLE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (sclFall) begin
                        bitNxt = '0;
                        unique case (rwBit)
                            I2C_WRITE: begin
                                stateNxt = ST_RX_DATA;
                                sdaNxt   = 1'b1;
                            end
                            I2C_READ: begin
                                stateNxt = ST_TX_DATA;
                                rdEnNxt  = 1'b1;
                                shiftNxt = rdDataIn;
                                sdaNxt   = rdDataIn[DATA_WIDTH-1];
                            end
                        endcase
                    end
                end
                ST_RX_DATA: begin
                    if (sclRise) begin
                        shiftNxt = {shiftReg[DATA_WIDTH-2:0], sdaLvl};
                        bitNxt   = bitCnt + 4'd1;
                    end else if (sclFall && bitCnt == LAST_BIT) begin
                        bitNxt   = '0;
                        stateNxt = ST_RX_ACK;
                        sdaNxt   = I2C_NACK;
                        if (!wrFifoFullIn) begin
                            wrDataNxt = shiftReg;
                            wrEnNxt   = 1'b1;
                            sdaNxt    = I2C_ACK;
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (sclFall) begin
                        stateNxt = ST_RX_DATA;
                        sdaNxt   = 1'b1;
                    end
                end
                ST_TX_DATA: begin
                    if (sclRise) begin
                        bitNxt = bitCnt + 4'd1;
                    end else if (sclFall) begin
                        if (bitCnt == LAST_BIT) begin
                            stateNxt = ST_TX_ACK;
                            sdaNxt   = 1'b1;
                        end else begin
                            shiftNxt = {shiftReg[DATA_WIDTH-2:0], 1'b0};
                            sdaNxt   = shiftReg[DATA_WIDTH-2];
                        end
                    end
                end
                ST_TX_ACK: begin
                    // A fall here always follows an ACKed rise; NACK leaves at the rise
                    if (sclRise && sdaLvl == I2C_NACK) begin
                        stateNxt = ST_IDLE;
                        busyNxt  = 1'b0;
                    end else if (sclFall) begin
                        bitNxt   = '0;
                        stateNxt = ST_TX_DATA;
                        rdEnNxt  = 1'b1;
                        shiftNxt = rdDataIn;
                        sdaNxt   = rdDataIn[DATA_WIDTH-1];
                    end
                end
                default: stateNxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-level bus master, FWFT read FIFO model,
// scoreboards for pushed bytes and bytes read from the bus.
module tb_i2c_slave;

    localparam int Q = 10;

    logic       clkIn = 1'b0;
    logic       rstIn;
    logic       sclIn;
    logic       sdaLow;
    logic       wrFifoFullIn;
    logic [7:0] rdDataIn;
    wire        sdaBus;
    wire  [7:0] wrDataOut;
    wire        wrFifoEnOut;
    wire        rdFifoEnOut;
    wire        busyOut;

    int checks = 0;
    int errors = 0;
    int pushCnt = 0;
    int popCnt = 0;

    logic [7:0] rdQ[$];
    logic [7:0] expRdQ[$];
    logic [7:0] wrExpQ[$];
    logic [8:0] expW;

    assign sdaBus = sdaLow ? 1'b0 : 1'bz;
    pullup (sdaBus);

    always #5 clkIn = ~clkIn;

    i2c_slave dut (
        .clkIn        (clkIn),
        .rstIn        (rstIn),
        .sclIn        (sclIn),
        .sdaBi        (sdaBus),
        .rdDataIn     (rdDataIn),
        .wrFifoFullIn (wrFifoFullIn),
        .wrDataOut    (wrDataOut),
        .wrFifoEnOut  (wrFifoEnOut),
        .rdFifoEnOut  (rdFifoEnOut),
        .busyOut      (busyOut)
    );

    task automatic checkEq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // FWFT read FIFO: head visible until the pop strobe is taken
    always @(posedge clkIn)
        if (rdFifoEnOut && rdQ.size() != 0) void'(rdQ.pop_front());

    always @(negedge clkIn) begin
        rdDataIn = (rdQ.size() != 0) ? rdQ[0] : 8'hEE;
        if (wrFifoEnOut) begin
            pushCnt++;
            if (wrExpQ.size() != 0) expW = {1'b0, wrExpQ.pop_front()};
            else expW = 9'h100;
            checkEq("wrData", 32'(wrDataOut), 32'(expW));
        end
        if (rdFifoEnOut) popCnt++;
        if (wrFifoEnOut || rdFifoEnOut)
            checkEq("strobeOverlap", 32'(wrFifoEnOut & rdFifoEnOut), 32'd0);
    end

    task automatic waitQ();
        repeat (Q) @(negedge clkIn);
    endtask

    task automatic clockBit(input logic drvLow, output logic smp);
        sdaLow = drvLow;
        waitQ();
        sclIn = 1'b1;
        waitQ();
        smp = sdaBus;
        waitQ();
        sclIn = 1'b0;
        waitQ();
    endtask

    task automatic startCond();
        sdaLow = 1'b1;
        waitQ();
        sclIn = 1'b0;
        waitQ();
    endtask

    task automatic restartCond();
        sdaLow = 1'b0;
        waitQ();
        sclIn = 1'b1;
        waitQ();
        startCond();
    endtask

    task automatic stopCond();
        sdaLow = 1'b1;
        waitQ();
        sclIn = 1'b1;
        waitQ();
        sdaLow = 1'b0;
        waitQ();
        waitQ();
    endtask

    task automatic sendByte(input logic [7:0] b, output logic ack);
        logic smp;
        for (int i = 7; i >= 0; i--) clockBit(~b[i], smp);
        clockBit(1'b0, ack);
    endtask

    task automatic readByte(input logic mAck);
        logic [7:0] d;
        logic [8:0] e;
        logic       smp;
        for (int i = 7; i >= 0; i--) clockBit(1'b0, d[i]);
        clockBit(mAck, smp);
        if (expRdQ.size() != 0) e = {1'b0, expRdQ.pop_front()};
        else e = 9'h100;
        checkEq("rdByte", 32'(d), 32'(e));
    endtask

    task automatic loadRd(input logic [7:0] b);
        rdQ.push_back(b);
        expRdQ.push_back(b);
    endtask

    initial begin
        logic ack;
        logic smp;
        int   p0;
        int   q0;
        sclIn = 1'b1;
        sdaLow = 1'b0;
        wrFifoFullIn = 1'b0;
        rdDataIn = 8'hEE;
        rstIn = 1'b1;
        repeat (3) @(negedge clkIn);
        checkEq("rstWrData", 32'(wrDataOut), 32'd0);
        checkEq("rstWrEn", 32'(wrFifoEnOut), 32'd0);
        checkEq("rstRdEn", 32'(rdFifoEnOut), 32'd0);
        checkEq("rstBusy", 32'(busyOut), 32'd0);
        checkEq("rstSda", 32'(sdaBus), 32'd1);
        rstIn = 1'b0;
        waitQ();

        // write two bytes
        p0 = pushCnt;
        startCond();
        sendByte(8'hA0, ack);
        checkEq("t1AddrAck", 32'(ack), 32'd0);
        checkEq("t1Busy", 32'(busyOut), 32'd1);
        wrExpQ.push_back(8'hA5);
        sendByte(8'hA5, ack);
        checkEq("t1Ack1", 32'(ack), 32'd0);
        wrExpQ.push_back(8'h3C);
        sendByte(8'h3C, ack);
        checkEq("t1Ack2", 32'(ack), 32'd0);
        stopCond();
        checkEq("t1BusyStop", 32'(busyOut), 32'd0);
        checkEq("t1Pushes", 32'(pushCnt - p0), 32'd2);

        // read two bytes, NACK the last
        loadRd(8'h5A);
        loadRd(8'hC3);
        q0 = popCnt;
        startCond();
        sendByte(8'hA1, ack);
        checkEq("t2AddrAck", 32'(ack), 32'd0);
        readByte(1'b1);
        readByte(1'b0);
        checkEq("t2SdaRel", 32'(sdaBus), 32'd1);
        checkEq("t2Pops", 32'(popCnt - q0), 32'd2);
        stopCond();

        // foreign address ignored
        p0 = pushCnt;
        q0 = popCnt;
        startCond();
        sendByte(8'hA2, ack);
        checkEq("t3AddrNack", 32'(ack), 32'd1);
        checkEq("t3Busy", 32'(busyOut), 32'd0);
        stopCond();
        startCond();
        sendByte(8'hA0, ack);
        checkEq("t3ReAddrAck", 32'(ack), 32'd0);
        stopCond();
        checkEq("t3Strobes", 32'((pushCnt - p0) + (popCnt - q0)), 32'd0);

        // write FIFO full
        p0 = pushCnt;
        startCond();
        sendByte(8'hA0, ack);
        checkEq("t4AddrAck", 32'(ack), 32'd0);
        wrFifoFullIn = 1'b1;
        sendByte(8'h11, ack);
        checkEq("t4FullNack", 32'(ack), 32'd1);
        wrFifoFullIn = 1'b0;
        wrExpQ.push_back(8'h22);
        sendByte(8'h22, ack);
        checkEq("t4Ack", 32'(ack), 32'd0);
        stopCond();
        checkEq("t4Pushes", 32'(pushCnt - p0), 32'd1);

        // repeated start turns write into read
        p0 = pushCnt;
        startCond();
        sendByte(8'hA0, ack);
        checkEq("t5AddrAck", 32'(ack), 32'd0);
        wrExpQ.push_back(8'h77);
        sendByte(8'h77, ack);
        checkEq("t5DataAck", 32'(ack), 32'd0);
        loadRd(8'h96);
        q0 = popCnt;
        restartCond();
        sendByte(8'hA1, ack);
        checkEq("t5RdAddrAck", 32'(ack), 32'd0);
        checkEq("t5PopEarly", 32'(popCnt - q0), 32'd1);
        checkEq("t5Busy", 32'(busyOut), 32'd1);
        readByte(1'b0);
        stopCond();
        checkEq("t5Pushes", 32'(pushCnt - p0), 32'd1);

        // reset in the middle of a read byte
        rdQ.push_back(8'h00);
        startCond();
        sendByte(8'hA1, ack);
        checkEq("t6AddrAck", 32'(ack), 32'd0);
        for (int i = 0; i < 3; i++) clockBit(1'b0, smp);
        checkEq("t6Bit5", 32'(smp), 32'd0);
        sdaLow = 1'b0;
        waitQ();
        sclIn = 1'b1;
        repeat (3) @(negedge clkIn);
        checkEq("t6SdaDriven", 32'(sdaBus), 32'd0);
        rstIn = 1'b1;
        #1;
        checkEq("t6SdaRel", 32'(sdaBus), 32'd1);
        checkEq("t6Busy", 32'(busyOut), 32'd0);
        checkEq("t6WrData", 32'(wrDataOut), 32'd0);
        checkEq("t6Strobes", 32'({wrFifoEnOut, rdFifoEnOut}), 32'd0);
        repeat (3) @(negedge clkIn);
        rstIn = 1'b0;
        waitQ();
        sclIn = 1'b0;
        waitQ();
        sclIn = 1'b1;
        waitQ();
        p0 = pushCnt;
        startCond();
        sendByte(8'hA0, ack);
        checkEq("t6AddrAck2", 32'(ack), 32'd0);
        wrExpQ.push_back(8'h01);
        sendByte(8'h01, ack);
        checkEq("t6DataAck", 32'(ack), 32'd0);
        stopCond();
        checkEq("t6Pushes", 32'(pushCnt - p0), 32'd1);

        checkEq("wrPending", 32'(wrExpQ.size()), 32'd0);
        checkEq("rdPending", 32'(expRdQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
